// File: rtl/iter_alu.sv
// Handshaked ALU: single-cycle logic/compare ops plus iterative shift-add multiply
// and restoring divide, with the result registered behind a valid/ready interface.
module iter_alu #(
    parameter int WIDTH     = 32,
    parameter int ECA_CONST = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] alu_in_1,
    input  logic [WIDTH-1:0] alu_in_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             alu_bcond
);

    // Handshake: a request transfers on a rising edge with in_valid && in_ready,
    // a result transfers on a rising edge with out_valid && out_ready; neither
    // valid depends combinationally on the matching ready.

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_XOR   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_AND   = 5'd4;
    localparam logic [4:0] OP_SLL   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_SLT   = 5'd8;
    localparam logic [4:0] OP_SLTU  = 5'd9;
    localparam logic [4:0] OP_ECA   = 5'd10;
    localparam logic [4:0] OP_BEQ   = 5'd11;
    localparam logic [4:0] OP_BNE   = 5'd12;
    localparam logic [4:0] OP_BLT   = 5'd13;
    localparam logic [4:0] OP_BGE   = 5'd14;
    localparam logic [4:0] OP_BLTU  = 5'd15;
    localparam logic [4:0] OP_BGEU  = 5'd16;
    localparam logic [4:0] OP_MUL   = 5'd17;
    localparam logic [4:0] OP_MULHU = 5'd18;
    localparam logic [4:0] OP_DIVU  = 5'd19;
    localparam logic [4:0] OP_REMU  = 5'd20;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [4:0]       op_q,        op_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic [WIDTH-1:0] acc_hi_q,    acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q,    acc_lo_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic             bcond_q,     bcond_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q,  in_ready_d;

    logic [WIDTH-1:0] sc_result;
    logic             sc_bcond;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] eca_diff;
    logic [SW-1:0]    shamt;
    logic             req_iter;
    logic             op_is_mul;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nx;
    logic [WIDTH-1:0] mul_lo_nx;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic             div_ok;
    logic [WIDTH-1:0] div_hi_nx;
    logic [WIDTH-1:0] div_lo_nx;

    assign diff     = alu_in_1 - alu_in_2;
    assign eca_diff = alu_in_1 - WIDTH'(ECA_CONST);
    assign shamt    = alu_in_2[SW-1:0];
    assign req_iter = (alu_op == OP_MUL) || (alu_op == OP_MULHU) ||
                      (alu_op == OP_DIVU) || (alu_op == OP_REMU);
    assign op_is_mul = (op_q == OP_MUL) || (op_q == OP_MULHU);

    always_comb begin
        sc_result = '0;
        sc_bcond  = 1'b0;
        case (alu_op)
            OP_ADD:  sc_result = alu_in_1 + alu_in_2;
            OP_SUB:  sc_result = diff;
            OP_XOR:  sc_result = alu_in_1 ^ alu_in_2;
            OP_OR:   sc_result = alu_in_1 | alu_in_2;
            OP_AND:  sc_result = alu_in_1 & alu_in_2;
            OP_SLL:  sc_result = alu_in_1 << shamt;
            OP_SRL:  sc_result = alu_in_1 >> shamt;
            OP_SRA:  sc_result = $unsigned($signed(alu_in_1) >>> shamt);
            OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, $signed(alu_in_1) < $signed(alu_in_2)};
            OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, alu_in_1 < alu_in_2};
            OP_ECA: begin
                sc_result = eca_diff;
                sc_bcond  = (eca_diff == '0);
            end
            OP_BEQ: begin
                sc_result = diff;
                sc_bcond  = (diff == '0);
            end
            OP_BNE: begin
                sc_result = diff;
                sc_bcond  = (diff != '0);
            end
            // Signed/unsigned compares use the operands so overflow in diff is irrelevant
            OP_BLT: begin
                sc_result = diff;
                sc_bcond  = $signed(alu_in_1) < $signed(alu_in_2);
            end
            OP_BGE: begin
                sc_result = diff;
                sc_bcond  = $signed(alu_in_1) >= $signed(alu_in_2);
            end
            OP_BLTU: begin
                sc_result = diff;
                sc_bcond  = alu_in_1 < alu_in_2;
            end
            OP_BGEU: begin
                sc_result = diff;
                sc_bcond  = alu_in_1 >= alu_in_2;
            end
            default: begin
                sc_result = '0;
                sc_bcond  = 1'b0;
            end
        endcase
    end

    // Multiply: acc_hi:acc_lo holds partial product over the shifting multiplier.
    // Divide: acc_hi is the remainder, acc_lo shifts dividend out and quotient in.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, a_q} : '0);
        mul_hi_nx = mul_sum[WIDTH:1];
        mul_lo_nx = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, b_q};
        div_ok    = ~div_trial[WIDTH];
        div_hi_nx = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_lo_nx = {acc_lo_q[WIDTH-2:0], div_ok};
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        bcond_d     = bcond_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d       = alu_op;
                    a_d        = alu_in_1;
                    b_d        = alu_in_2;
                    in_ready_d = 1'b0;
                    if (req_iter) begin
                        state_d  = S_CALC;
                        cnt_d    = CW'(WIDTH);
                        acc_hi_d = '0;
                        acc_lo_d = ((alu_op == OP_MUL) || (alu_op == OP_MULHU)) ? alu_in_2 : alu_in_1;
                    end else begin
                        state_d     = S_DONE;
                        result_d    = sc_result;
                        bcond_d     = sc_bcond;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_CALC: begin
                cnt_d    = cnt_q - 1'b1;
                acc_hi_d = op_is_mul ? mul_hi_nx : div_hi_nx;
                acc_lo_d = op_is_mul ? mul_lo_nx : div_lo_nx;
                if (cnt_q == CW'(1)) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    bcond_d     = 1'b0;
                    case (op_q)
                        OP_MUL:   result_d = mul_lo_nx;
                        OP_MULHU: result_d = mul_hi_nx;
                        OP_DIVU:  result_d = div_lo_nx;
                        default:  result_d = div_hi_nx;
                    endcase
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            bcond_q     <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            bcond_q     <= bcond_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign alu_result = result_q;
    assign alu_bcond  = bcond_q;

endmodule

// File: tb/tb_iter_alu.sv
// Bench for iter_alu: directed vector table, randomized ops against an arithmetic
// reference model, and hand sequences for backpressure and mid-operation reset.
module tb_iter_alu;

    localparam int W   = 32;
    localparam int ECA = 10;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [4:0]   alu_op = '0;
    logic [W-1:0] alu_in_1 = '0;
    logic [W-1:0] alu_in_2 = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] alu_result;
    logic         alu_bcond;

    int n_vec = 0;
    int n_err = 0;

    iter_alu #(.WIDTH(W), .ECA_CONST(ECA)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .alu_in_1   (alu_in_1),
        .alu_in_2   (alu_in_2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_result (alu_result),
        .alu_bcond  (alu_bcond)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        logic         exp_bc;
        int           exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model straight from the opcode definitions, using wide arithmetic.
    task automatic model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic c);
        logic [2*W-1:0] p;
        int sh;
        p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        sh = int'(b % W);
        c  = 1'b0;
        case (op)
            0:  r = a + b;
            1:  r = a - b;
            2:  r = a ^ b;
            3:  r = a | b;
            4:  r = a & b;
            5:  r = a << sh;
            6:  r = a >> sh;
            7:  r = $unsigned($signed(a) >>> sh);
            8:  r = ($signed(a) < $signed(b)) ? 1 : 0;
            9:  r = (a < b) ? 1 : 0;
            10: begin r = a - ECA; c = (a == ECA); end
            11: begin r = a - b; c = (a == b); end
            12: begin r = a - b; c = (a != b); end
            13: begin r = a - b; c = $signed(a) < $signed(b); end
            14: begin r = a - b; c = $signed(a) >= $signed(b); end
            15: begin r = a - b; c = a < b; end
            16: begin r = a - b; c = a >= b; end
            17: r = p[W-1:0];
            18: r = p[2*W-1:W];
            19: r = (b == 0) ? '1 : a / b;
            20: r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
    endtask

    // Issue one op with out_ready high; returns result, bcond and accept-to-valid latency.
    task automatic do_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output logic bc, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_before_accept", {31'b0, in_ready}, 1);
        in_valid = 1'b1;
        alu_op   = op;
        alu_in_1 = a;
        alu_in_2 = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_in_1 = $urandom;
        alu_in_2 = $urandom;
        alu_op   = 5'($urandom_range(0, 31));
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("out_valid_timeout", {31'b0, out_valid}, 1);
        check("in_ready_in_done", {31'b0, in_ready}, 0);
        res = alu_result;
        bc  = alu_bcond;
        @(posedge clk);
        #1;
        check("out_valid_drop", {31'b0, out_valid}, 0);
    endtask

    vec_t vt[$];
    logic [W-1:0] r, er;
    logic         c, ec;
    int           lat;
    logic [4:0]   rop;
    logic [W-1:0] ra, rb;

    initial begin
        vt.push_back('{5'd0,  32'd5,         32'd7,         32'd12,        1'b0, 1});
        vt.push_back('{5'd13, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFE,  1'b1, 1});
        vt.push_back('{5'd15, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFE,  1'b0, 1});
        vt.push_back('{5'd14, 32'h80000000,  32'h7FFFFFFF,  32'h00000001,  1'b0, 1});
        vt.push_back('{5'd10, 32'd10,        32'd99,        32'd0,         1'b1, 1});
        vt.push_back('{5'd17, 32'h12345678,  32'h10,        32'h23456780,  1'b0, 33});
        vt.push_back('{5'd18, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  1'b0, 33});
        vt.push_back('{5'd19, 32'd100,       32'd7,         32'd14,        1'b0, 33});
        vt.push_back('{5'd20, 32'd100,       32'd7,         32'd2,         1'b0, 33});
        vt.push_back('{5'd19, 32'd5,         32'd0,         32'hFFFFFFFF,  1'b0, 33});
        vt.push_back('{5'd20, 32'd5,         32'd0,         32'd5,         1'b0, 33});
        vt.push_back('{5'd1,  32'd3,         32'd5,         32'hFFFFFFFE,  1'b0, 1});
        vt.push_back('{5'd8,  32'h80000000,  32'd1,         32'd1,         1'b0, 1});
        vt.push_back('{5'd9,  32'h80000000,  32'd1,         32'd0,         1'b0, 1});
        vt.push_back('{5'd5,  32'd1,         32'd35,        32'd8,         1'b0, 1});
        vt.push_back('{5'd6,  32'h80000000,  32'd31,        32'd1,         1'b0, 1});
        vt.push_back('{5'd11, 32'd5,         32'd5,         32'd0,         1'b1, 1});
        vt.push_back('{5'd12, 32'd5,         32'd5,         32'd0,         1'b0, 1});
        vt.push_back('{5'd16, 32'd1,         32'hFFFFFFFF,  32'd2,         1'b0, 1});
        vt.push_back('{5'd2,  32'hF0F0F0F0,  32'hFF00FF00,  32'h0FF00FF0,  1'b0, 1});
        vt.push_back('{5'd3,  32'hF0F0F0F0,  32'h0000FF00,  32'hF0F0FFF0,  1'b0, 1});
        vt.push_back('{5'd4,  32'hF0F0F0F0,  32'h0000FF00,  32'h0000F000,  1'b0, 1});
        vt.push_back('{5'd25, 32'h12345678,  32'h1,         32'd0,         1'b0, 1});

        // Reset values, sampled while reset is still asserted.
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", {31'b0, in_ready}, 1);
        check("reset_out_valid", {31'b0, out_valid}, 0);
        check("reset_result", alu_result, 0);
        check("reset_bcond", {31'b0, alu_bcond}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vt[i]) begin
            do_op(vt[i].op, vt[i].a, vt[i].b, r, c, lat);
            check($sformatf("vec%0d_op%0d_result", i, vt[i].op), r, vt[i].exp_res);
            check($sformatf("vec%0d_op%0d_bcond", i, vt[i].op), {31'b0, c}, {31'b0, vt[i].exp_bc});
            check($sformatf("vec%0d_op%0d_latency", i, vt[i].op), lat, vt[i].exp_lat);
        end

        for (int k = 0; k < 150; k++) begin
            rop = 5'($urandom_range(0, 22));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : $urandom;
            if ($urandom_range(0, 7) == 0) ra = (rop == 5'd10) ? W'(ECA) : rb;
            model(rop, ra, rb, er, ec);
            do_op(rop, ra, rb, r, c, lat);
            check($sformatf("rnd%0d_op%0d_result", k, rop), r, er);
            check($sformatf("rnd%0d_op%0d_bcond", k, rop), {31'b0, c}, {31'b0, ec});
            check($sformatf("rnd%0d_op%0d_latency", k, rop), lat, (rop >= 17 && rop <= 20) ? 33 : 1);
        end

        // Backpressure: result held while out_ready is low, new requests ignored.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        alu_op    = 5'd7;
        alu_in_1  = 32'h80000000;
        alu_in_2  = 32'd4;
        @(posedge clk);
        #1;
        alu_op   = 5'd0;
        alu_in_1 = 32'd1;
        alu_in_2 = 32'd1;
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", {31'b0, out_valid}, 1);
            check("bp_result", alu_result, 32'hF8000000);
            check("bp_bcond", {31'b0, alu_bcond}, 0);
            check("bp_in_ready", {31'b0, in_ready}, 0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", {31'b0, out_valid}, 0);
        check("bp_release_ready", {31'b0, in_ready}, 1);
        @(posedge clk);
        #1;
        check("bp_no_extra_op", {31'b0, out_valid}, 0);

        // Reset in the middle of a divide aborts it without a stale result.
        @(negedge clk);
        in_valid = 1'b1;
        alu_op   = 5'd19;
        alu_in_1 = 32'd100;
        alu_in_2 = 32'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_mid_out_valid", {31'b0, out_valid}, 0);
        check("rst_mid_result", alu_result, 0);
        check("rst_mid_in_ready", {31'b0, in_ready}, 1);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) break;
        end
        check("rst_no_stale_valid", {31'b0, out_valid}, 0);
        do_op(5'd0, 32'd1, 32'd1, r, c, lat);
        check("rst_after_add_result", r, 32'd2);
        check("rst_after_add_latency", lat, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Parametrised, handshaked ALU for the multi-cycle datapath.
- Supersedes the fixed 32-bit combinational ALU:
  - adds SRA, SLT/SLTU, unsigned branch compares, iterative MUL/MULHU/DIVU/REMU.
  - registers its output behind a valid/ready interface.
- Sits between the operand-select muxes and the ALUOut register; the control FSM waits on out_valid.

Parameters:
WIDTH, 32, datapath width in bits (>=8, power of two)
ECA_CONST, 10, constant subtracted by ECA (ecall x17 check)

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request
in_ready  output  1  unit can accept a request
alu_op  input  5  operation code (sampled on accept)
alu_in_1  input  WIDTH  operand A
alu_in_2  input  WIDTH  operand B
out_valid  output  1  result available
out_ready  input  1  consumer takes result
alu_result  output  WIDTH  registered result
alu_bcond  output  1  registered branch/ecall condition

Behaviour:
- Reset (reset_n low, async):
  - state=IDLE; in_ready=1; out_valid=0; alu_result=0; alu_bcond=0.
  - Internal accumulators cleared.
  - Asserting reset mid-operation aborts it; no result is ever delivered for it.
- Opcodes (decimal):
  - 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 ECA, 11 BEQ, 12 BNE, 13 BLT, 14 BGE, 15 BLTU, 16 BGEU, 17 MUL, 18 MULHU, 19 DIVU, 20 REMU.
  - Other codes: result=0, bcond=0, single-cycle class.
- Arithmetic (all modulo 2^WIDTH):
  - Shifts use alu_in_2[$clog2(WIDTH)-1:0] only; SRA is arithmetic.
  - SLT/SLTU: result = 1 or 0.
  - ECA: result = A - ECA_CONST; bcond = (result==0).
  - Branch ops: result = A - B.
    - BEQ/BNE: result ==0 / !=0.
    - BLT/BGE: signed compare of A,B.
    - BLTU/BGEU: unsigned compare.
    - Compares are computed directly from the operands, not from the sign of the difference, so overflow cannot flip them.
  - Non-branch ops: bcond = 0.
  - MUL: low WIDTH bits of A*B (unsigned product). MULHU: high WIDTH bits.
  - DIVU/REMU: restoring division.
    - B==0: DIVU = all ones, REMU = A (no exception).
- FSM states IDLE, CALC, DONE:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch op and operands.
    - Single-cycle op: compute and load result/bcond, go to DONE.
    - MUL/MULHU/DIVU/REMU: go to CALC, counter=WIDTH.
  - CALC: one shift-add (mul) or shift-subtract (div) step per cycle; counter decrements.
    - When counter reaches 1, the final step loads result; next state DONE.
  - DONE: out_valid=1; result/bcond held stable until out_ready. On out_valid&&out_ready go to IDLE; out_valid drops next cycle.
- in_ready is 1 only in IDLE; no request is accepted in CALC or DONE.
- Latency, accept edge to first out_valid edge:
  - single-cycle ops: 1 cycle.
  - iterative ops: WIDTH+1 cycles.
- Throughput with out_ready tied high:
  - single-cycle ops: one op per 2 cycles.
  - iterative ops: one op per WIDTH+2 cycles.
- Operand changes after accept have no effect on the op in flight.
- alu_result/alu_bcond hold their last value in IDLE and CALC; only out_valid qualifies them.

Test Plan:
- Reset then ADD A=5, B=7, out_ready=1 -> out_valid one cycle after accept, alu_result=12, bcond=0; in_ready=0 during DONE.
- BLT A=0xFFFFFFFF, B=1 -> bcond=1. BLTU same operands -> bcond=0. BGE A=0x80000000, B=0x7FFFFFFF -> bcond=0 (overflow case). ECA A=10 -> result=0, bcond=1.
- MUL 0x12345678*0x10 -> 0x23456780 with out_valid exactly 33 cycles after accept. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- DIVU 100/7 -> 14; REMU 100%7 -> 2; DIVU 5/0 -> 0xFFFFFFFF; REMU 5%0 -> 5.
- Backpressure: SRA A=0x80000000, B=4 with out_ready=0 for 5 cycles -> out_valid and result 0xF8000000 stable, in_ready=0 throughout, in_valid ignored; completes when out_ready rises.
- Pulse reset_n low mid-CALC of a DIVU -> out_valid=0, result=0, in_ready=1 immediately; a subsequent ADD 1+1 -> 2 with no stale result delivered.
